i2c_master_ctrl: RTL and testbench
==================================

// Module: i2c_master_ctrl
// PURPOSE
//  Synthesizable single-byte I2C master sequencer; replaces bench-side bit-banging of sclk/sda.
//  Accepts one transaction request (7-bit address, R/W, one data byte) and runs the full
//  sequence START, ADDR, RW, ACK, DATA, ACK, STOP on an open-drain bus.
//  Sits between a register/host interface and the I2C pads; slave side is unchanged.
// PARAMETERS
//  DIV    50  system clocks per SCL quarter-phase (>=2); SCL period = 4*DIV clocks
//  DIV_W  6   width of phase counter; must satisfy 2**DIV_W >= DIV
// PORTS
//  clk        in   1  single system clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  start      in   1  request pulse; accepted only when ready=1
//  rw         in   1  0=write, 1=read; sampled on accept
//  i_adress   in   7  slave address, sent MSB first; sampled on accept
//  i_data     in   8  write byte, sent MSB first; sampled on accept
//  nack_last  in   1  read only: 1=master NACKs the byte, 0=master ACKs; sampled on accept
//  ready      out  1  1 when idle and able to accept start
//  busy       out  1  1 from accept cycle until done
//  done       out  1  one-clock pulse at end of transaction
//  ack_err    out  1  1 if slave NACKed address or write byte; valid with done, held until next accept
//  o_data     out  8  read byte; valid with done, held until next accept
//  sclk       out  1  SCL level (1=released high)
//  sda_oe     out  1  1=pull SDA low, 0=release (pad pull-up gives 1)
//  sda_i      in   1  SDA pad readback
//  scl_i      in   1  SCL pad readback; used only with I2C_CLK_STRETCH_EN
// BEHAVIOUR
//  Reset: sclk=1, sda_oe=0, ready=1, busy=0, done=0, ack_err=0, o_data=0, state=IDLE.
//  rst mid-transaction: bus abandoned next cycle at reset values; no STOP generated.
//  rst and start in same cycle: rst wins, request dropped. start while busy: ignored.
//  Timebase: phase counter counts 0..DIV-1; each bit slot = 4 phases P0..P3.
//   P0 SCL low, drive SDA; P1,P2 SCL high; P3 SCL low. Sample sda_i on last clk of P2.
//  States / slots (4 phases each):
//   IDLE  -> START on accepted start; latches rw, i_adress, i_data, nack_last; clears ack_err.
//   START 1 slot: SCL=1,SDA=1 for P0-P1; SDA low P2; SCL low P3.
//   ADDR  7 slots, address bits [6]..[0].
//   RW    1 slot, drives rw.
//   ACK1  1 slot, SDA released; sda_i=1 -> ack_err=1, next STOP; else DATA.
//   DATA  8 slots. Write: drive byte MSB first. Read: release SDA, shift sda_i into o_data.
//   ACK2  1 slot. Write: release, sda_i=1 -> ack_err=1 (still continue to STOP).
//         Read: sda_oe=!nack_last (drive low = ACK).
//   STOP  1 slot: SDA low P0; SCL high P1; SDA released P2; idle P3; then done=1, IDLE.
//  Latency: accept at cycle T; full transaction done at T+80*DIV; address NACK done at T+44*DIV.
//  ready = !busy; ready returns 1 in the cycle after done.
//  sda_oe never toggles while sclk=1 except in START/STOP slots.
// CONFIGURATION
//  I2C_CLK_STRETCH_EN defined: in P1/P2 the phase counter holds while scl_i=0 (slave
//   stretching); each held clock adds one clock to latency. Undefined: scl_i ignored,
//   timing strictly fixed as above.
// TESTING  (DIV=4)
//  1 write 0x27/0x18, sda_i low in ACK slots -> SDA bits 0100111,0,00011000; done at T+320, ack_err=0
//  2 read 0x27, slave drives 0xA5, nack_last=1 -> o_data=0xA5, sda_oe=0 through ACK2, done at T+320
//  3 write 0x27, sda_i=1 in ACK1 -> ack_err=1, no DATA slots, STOP seen, done at T+176
//  4 start pulse at T+40 while busy -> ignored, single done at T+320; read with nack_last=0 -> sda_oe=1 in ACK2
//  5 rst at T+120 -> next cycle sclk=1, sda_oe=0, busy=0, no done; new write then completes at +320
//  6 with I2C_CLK_STRETCH_EN: scl_i held low 100 clks in address bit 3 P1 -> done at T+420, data intact

Source files
------------

// File: rtl/i2c_master_ctrl_if.sv
// Host request/response handshake plus I2C pad signals for i2c_master_ctrl.
// master modport: the sequencer's view; slave modport: host logic and pads.
interface i2c_master_ctrl_if;
    logic       start;
    logic       rw;
    logic [6:0] i_adress;
    logic [7:0] i_data;
    logic       nack_last;
    logic       ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] o_data;
    logic       sclk;
    logic       sda_oe;
    logic       sda_i;
    logic       scl_i;

    modport master (
        input  start, rw, i_adress, i_data, nack_last, sda_i, scl_i,
        output ready, busy, done, ack_err, o_data, sclk, sda_oe
    );

    modport slave (
        output start, rw, i_adress, i_data, nack_last, sda_i, scl_i,
        input  ready, busy, done, ack_err, o_data, sclk, sda_oe
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, 7-bit address, R/W, ACK, one data byte, ACK, STOP.
// Optional SCL clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_ctrl #(
    parameter int DIV   = 50,
    parameter int DIV_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    i2c_master_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_RW, S_ACK1, S_DATA, S_ACK2, S_STOP
    } state_t;

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       phase_reg, phase_next;
    logic [2:0]       bit_reg, bit_next;
    logic             rw_reg, rw_next;
    logic [6:0]       addr_reg, addr_next;
    logic [7:0]       wdata_reg, wdata_next;
    logic             nack_reg, nack_next;
    logic             ack_err_reg, ack_err_next;
    logic [7:0]       rdata_reg, rdata_next;
    logic             done_reg, done_next;

    logic hold, tick, sample, slot_end, accept, busy_int, scl_mid;
    logic sclk_int, sda_oe_int;

`ifdef I2C_CLK_STRETCH_EN
    // A slave holding SCL low freezes the timebase while SCL should be high.
    assign hold = (state_reg != S_IDLE) && (phase_reg == 2'd1 || phase_reg == 2'd2) && !bus.scl_i;
`else
    logic unused_scl;
    assign unused_scl = bus.scl_i;
    assign hold       = 1'b0;
`endif

    assign busy_int = (state_reg != S_IDLE) || done_reg;
    assign accept   = bus.start && !busy_int;
    assign tick     = (cnt_reg == CNT_LAST) && !hold;
    assign sample   = tick && (phase_reg == 2'd2);
    assign slot_end = tick && (phase_reg == 2'd3);
    assign scl_mid  = (phase_reg == 2'd1) || (phase_reg == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            phase_reg   <= 2'd0;
            bit_reg     <= 3'd0;
            rw_reg      <= 1'b0;
            addr_reg    <= 7'd0;
            wdata_reg   <= 8'd0;
            nack_reg    <= 1'b0;
            ack_err_reg <= 1'b0;
            rdata_reg   <= 8'd0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            phase_reg   <= phase_next;
            bit_reg     <= bit_next;
            rw_reg      <= rw_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            nack_reg    <= nack_next;
            ack_err_reg <= ack_err_next;
            rdata_reg   <= rdata_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        phase_next   = phase_reg;
        bit_next     = bit_reg;
        rw_next      = rw_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        nack_next    = nack_reg;
        ack_err_next = ack_err_reg;
        rdata_next   = rdata_reg;
        done_next    = 1'b0;
        if (state_reg == S_IDLE) begin
            cnt_next   = '0;
            phase_next = 2'd0;
            bit_next   = 3'd0;
            if (accept) begin
                state_next   = S_START;
                rw_next      = bus.rw;
                addr_next    = bus.i_adress;
                wdata_next   = bus.i_data;
                nack_next    = bus.nack_last;
                ack_err_next = 1'b0;
            end
        end else begin
            if (tick) begin
                cnt_next   = '0;
                phase_next = phase_reg + 2'd1;
            end else if (!hold) begin
                cnt_next = cnt_reg + DIV_W'(1);
            end
            if (sample) begin
                case (state_reg)
                    S_ACK1:  if (bus.sda_i) ack_err_next = 1'b1;
                    S_DATA:  if (rw_reg) rdata_next = {rdata_reg[6:0], bus.sda_i};
                    S_ACK2:  if (!rw_reg && bus.sda_i) ack_err_next = 1'b1;
                    default: ;
                endcase
            end
            // Address and write byte are shifted out MSB first, one bit per slot.
            if (slot_end) begin
                case (state_reg)
                    S_START: begin
                        state_next = S_ADDR;
                        bit_next   = 3'd6;
                    end
                    S_ADDR: begin
                        addr_next = {addr_reg[5:0], 1'b0};
                        if (bit_reg == 3'd0) state_next = S_RW;
                        else bit_next = bit_reg - 3'd1;
                    end
                    S_RW: state_next = S_ACK1;
                    S_ACK1: begin
                        if (ack_err_reg) begin
                            state_next = S_STOP;
                        end else begin
                            state_next = S_DATA;
                            bit_next   = 3'd7;
                        end
                    end
                    S_DATA: begin
                        wdata_next = {wdata_reg[6:0], 1'b0};
                        if (bit_reg == 3'd0) state_next = S_ACK2;
                        else bit_next = bit_reg - 3'd1;
                    end
                    S_ACK2: state_next = S_STOP;
                    S_STOP: begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end
                    default: state_next = S_IDLE;
                endcase
            end
        end
    end

    // SDA only changes while SCL is low, except the START fall and STOP rise.
    always_comb begin
        sclk_int   = 1'b1;
        sda_oe_int = 1'b0;
        case (state_reg)
            S_START: begin
                sclk_int   = (phase_reg != 2'd3);
                sda_oe_int = phase_reg[1];
            end
            S_ADDR: begin
                sclk_int   = scl_mid;
                sda_oe_int = !addr_reg[6];
            end
            S_RW: begin
                sclk_int   = scl_mid;
                sda_oe_int = !rw_reg;
            end
            S_ACK1: sclk_int = scl_mid;
            S_DATA: begin
                sclk_int   = scl_mid;
                sda_oe_int = !rw_reg && !wdata_reg[7];
            end
            S_ACK2: begin
                sclk_int   = scl_mid;
                sda_oe_int = rw_reg && !nack_reg;
            end
            S_STOP: begin
                sclk_int   = (phase_reg != 2'd0);
                sda_oe_int = !phase_reg[1];
            end
            default: ;
        endcase
    end

    assign bus.sclk    = sclk_int;
    assign bus.sda_oe  = sda_oe_int;
    assign bus.busy    = busy_int;
    assign bus.ready   = !busy_int;
    assign bus.done    = done_reg;
    assign bus.ack_err = ack_err_reg;
    assign bus.o_data  = rdata_reg;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: slot-level model of an I2C slave plus expected
// latency, bit order and status derived from transaction parameters.
module tb_i2c_master_ctrl;
    localparam int DIV  = 4;
    localparam int SLOT = 4 * DIV;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   txn_no   = 0;
    logic [7:0] exp_odata;
    logic       exp_ackerr;

    i2c_master_ctrl_if bus ();

    i2c_master_ctrl #(.DIV(DIV), .DIV_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slots: 0 START, 1-7 ADDR, 8 RW, 9 ACK1, 10-17 DATA, 18 ACK2, 19 STOP
    // (address NACK: STOP at slot 10).
    task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                           input logic nack_last, input logic ack1, input logic ack2,
                           input logic [7:0] rbyte, input int xs_at, input int rst_at,
                           input int st_at, input int st_len);
        int lat, n, held, n_eff, slot, pos, done_n, starts, stops, viol, rd_oe, extra, stop_slot;
        logic [6:0] addr_obs;
        logic [7:0] data_obs;
        logic rw_obs, ack2_oe_obs, prev_scl, prev_line, prev_oe, line, slave, stretch, seen_rst;
        lat       = (ack1 ? 44 : 80) * DIV + st_len;
        stop_slot = ack1 ? 10 : 19;
        held = 0; done_n = -1; starts = 0; stops = 0; viol = 0; rd_oe = 0; extra = 0;
        addr_obs = '0; data_obs = '0; rw_obs = 1'b0; ack2_oe_obs = 1'b0; seen_rst = 1'b0;
        txn_no++;
        chk("ready_before_accept", bus.ready, 1);
        bus.rw = rw; bus.i_adress = addr; bus.i_data = wdata; bus.nack_last = nack_last;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        prev_scl = 1'b1; prev_line = 1'b1; prev_oe = 1'b0;
        for (n = 0; n < lat + 40; n++) begin
            if (bus.done) begin
                done_n = n;
                break;
            end
            n_eff   = n - held;
            slot    = n_eff / SLOT;
            pos     = n_eff % SLOT;
            stretch = (n >= st_at) && (n < st_at + st_len);
            if (stretch) held++;
            slave = 1'b1;
            if (slot == 9) slave = ack1;
            else if (!ack1 && rw && slot >= 10 && slot <= 17) slave = rbyte[17 - slot];
            else if (!ack1 && !rw && slot == 18) slave = ack2;
            line      = slave & ~bus.sda_oe;
            bus.sda_i = line;
            bus.scl_i = bus.sclk & ~stretch;
            if (pos == DIV) begin
                if (slot >= 1 && slot <= 7) addr_obs = {addr_obs[5:0], line};
                if (slot == 8) rw_obs = line;
                if (slot >= 10 && slot <= 17) data_obs = {data_obs[6:0], line};
                if (slot == 18) ack2_oe_obs = bus.sda_oe;
            end
            if (bus.sda_oe && (slot == 9 || (rw && !ack1 && slot >= 10 && slot <= 17))) rd_oe++;
            if (prev_scl && bus.sclk && prev_oe != bus.sda_oe && slot != 0 && slot != stop_slot) viol++;
            if (prev_scl && bus.sclk && prev_line && !line) starts++;
            if (prev_scl && bus.sclk && !prev_line && line) stops++;
            prev_scl = bus.sclk; prev_line = line; prev_oe = bus.sda_oe;
            if (n == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                seen_rst = 1'b1;
                break;
            end
            bus.start = (n == xs_at);
            step();
        end
        bus.start = 1'b0; bus.sda_i = 1'b1; bus.scl_i = 1'b1;
        if (rst_at >= 0) begin
            chk("rst_reached", seen_rst, 1);
            chk("rst_sclk", bus.sclk, 1);
            chk("rst_sda_oe", bus.sda_oe, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_ready", bus.ready, 1);
            exp_odata = 8'h00; exp_ackerr = 1'b0;
            for (int i = 0; i < 100 * DIV; i++) begin
                if (bus.done) extra++;
                step();
            end
            chk("rst_no_done", extra, 0);
            chk("rst_o_data", bus.o_data, exp_odata);
            $display("txn %0d: rw=%0d addr=0x%02h reset at cycle %0d", txn_no, rw, addr, rst_at);
            return;
        end
        if (!ack1 && rw) exp_odata = rbyte;
        exp_ackerr = ack1 | (!rw & ack2);
        chk("done_latency", done_n, lat);
        chk("busy_at_done", bus.busy, 1);
        chk("ack_err", bus.ack_err, exp_ackerr);
        chk("o_data", bus.o_data, exp_odata);
        chk("addr_bits", addr_obs, addr);
        chk("rw_bit", rw_obs, rw);
        chk("start_cond", starts, 1);
        chk("stop_cond", stops, 1);
        chk("sda_stable_scl_high", viol, 0);
        chk("released_while_slave_drives", rd_oe, 0);
        if (!ack1 && !rw) chk("write_bits", data_obs, wdata);
        if (!ack1 && rw) chk("ack2_drive", ack2_oe_obs, !nack_last);
        step();
        chk("done_pulse_width", bus.done, 0);
        chk("ready_after_done", bus.ready, 1);
        for (int i = 0; i < 2 * SLOT; i++) begin
            if (bus.done || bus.busy) extra++;
            step();
        end
        chk("no_extra_activity", extra, 0);
        chk("ack_err_held", bus.ack_err, exp_ackerr);
        $display("txn %0d: rw=%0d addr=0x%02h wdata=0x%02h done@%0d ack_err=%0d o_data=0x%02h",
                 txn_no, rw, addr, wdata, done_n, bus.ack_err, bus.o_data);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.rw = 1'b0; bus.i_adress = '0; bus.i_data = '0;
        bus.nack_last = 1'b0; bus.sda_i = 1'b1; bus.scl_i = 1'b1;
        exp_odata = 8'h00; exp_ackerr = 1'b0;
        step(); step(); step();
        chk("reset_sclk", bus.sclk, 1);
        chk("reset_sda_oe", bus.sda_oe, 0);
        chk("reset_ready", bus.ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_ack_err", bus.ack_err, 0);
        chk("reset_o_data", bus.o_data, 0);

        // rst and start together: request dropped
        bus.start = 1'b1; bus.i_adress = 7'h27;
        step();
        bus.start = 1'b0; rst = 1'b0;
        step(); step();
        chk("rst_wins_busy", bus.busy, 0);
        chk("rst_wins_sclk", bus.sclk, 1);

        run_txn(1'b0, 7'h27, 8'h18, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1, -1, 0);
        run_txn(1'b1, 7'h27, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, -1, -1, -1, 0);
        run_txn(1'b0, 7'h27, 8'h18, 1'b0, 1'b1, 1'b0, 8'h00, -1, -1, -1, 0);
        run_txn(1'b1, 7'h27, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 40, -1, -1, 0);
        run_txn(1'b0, 7'h27, 8'h18, 1'b0, 1'b1, 1'b0, 8'h00, -1, -1, -1, 0);
        run_txn(1'b0, 7'h55, 8'hC3, 1'b0, 1'b0, 1'b1, 8'h00, -1, -1, -1, 0);
        run_txn(1'b0, 7'h27, 8'h18, 1'b0, 1'b0, 1'b0, 8'h00, -1, 120, -1, 0);
        run_txn(1'b0, 7'h27, 8'h18, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1, -1, 0);
`ifdef I2C_CLK_STRETCH_EN
        run_txn(1'b0, 7'h27, 8'h18, 1'b0, 1'b0, 1'b0, 8'h00, -1, -1, 4 * SLOT + DIV, 100);
`endif
        for (int k = 0; k < 6; k++) begin
            run_txn(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 8'($urandom), -1, -1, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
